// File: rtl/vga_text_pkg.sv
// Shared constants and state encoding for the VGA text-line controller.
// Control codes are plain ints so each user can size them to its own char width.
package vga_text_pkg;

  localparam int CHAR_W      = 7;
  localparam int SYMBOLS_DEF = 16;

  localparam int CC_BS    = 8'h08;
  localparam int CC_LF    = 8'h0A;
  localparam int CC_FF    = 8'h0C;
  localparam int CC_PR_LO = 8'h20;
  localparam int CC_PR_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SHIFT,
    ST_CLEAR,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/vga_text_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
// Priority only moves when both sources contend, so the loser of a tie wins the next tie.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio_kbd;
  logic w_tie;

  assign w_tie = i_en && (i_req == 2'b11);

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (w_tie) o_gnt = r_prio_kbd ? 2'b10 : 2'b01;
      else       o_gnt = i_req;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_prio_kbd <= 1'b0;
    else if (w_tie) r_prio_kbd <= o_gnt[0];
  end

endmodule

// File: rtl/vga_text_ctrl.sv
// Single-line text buffer fed by CPU and keyboard echo via req/ack handshakes.
// Handles printable append/scroll, backspace and a slot-by-slot clear.
module vga_text_ctrl #(
  parameter int SYMBOLS = vga_text_pkg::SYMBOLS_DEF,
  parameter int CHAR_W  = vga_text_pkg::CHAR_W
) (
  input  logic                      clk_50,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic [CHAR_W-1:0]         cpu_char,
  output logic                      cpu_ack,
  input  logic                      kbd_req,
  input  logic [CHAR_W-1:0]         kbd_char,
  output logic                      kbd_ack,
  output logic [SYMBOLS*CHAR_W-1:0] characters,
  output logic [4:0]                count,
  output logic                      busy
);
  import vga_text_pkg::*;

  localparam int IW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  state_t            r_state;
  logic [CHAR_W-1:0] r_slots [SYMBOLS];
  logic [CHAR_W-1:0] r_char;
  logic              r_src;
  logic [4:0]        r_count;
  logic [IW-1:0]     r_clr_idx;
  logic              r_cpu_ack;
  logic              r_kbd_ack;

  logic [1:0] w_gnt;
  logic       w_print;
  logic       w_full;
  logic       w_bs;
  logic       w_clr_code;
  logic       w_clr_last;
  logic       w_src_req;
  logic       w_ack_now;

  rr_arb2 u_arb (
    .i_clk (clk_50),
    .i_rst (reset),
    .i_en  (r_state == ST_IDLE),
    .i_req ({kbd_req, cpu_req}),
    .o_gnt (w_gnt)
  );

  assign w_print    = (r_char >= CHAR_W'(CC_PR_LO)) &&
                      (r_char <= CHAR_W'(CC_PR_HI));
  assign w_full     = r_count >= 5'(SYMBOLS);
  assign w_bs       = r_char == CHAR_W'(CC_BS);
  assign w_clr_code = (r_char == CHAR_W'(CC_LF)) ||
                      (r_char == CHAR_W'(CC_FF));
  assign w_clr_last = r_clr_idx == IW'(SYMBOLS - 1);
  assign w_src_req  = r_src ? kbd_req : cpu_req;

  always_comb begin
    w_ack_now = 1'b0;
    unique case (r_state)
      ST_WRITE: w_ack_now = !(w_print && w_full) && !w_clr_code;
      ST_SHIFT: w_ack_now = 1'b1;
      ST_CLEAR: w_ack_now = w_clr_last;
      default:  w_ack_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_char    <= '0;
      r_src     <= 1'b0;
      r_count   <= '0;
      r_clr_idx <= '0;
      r_cpu_ack <= 1'b0;
      r_kbd_ack <= 1'b0;
      for (int i = 0; i < SYMBOLS; i++) r_slots[i] <= '0;
    end else begin
      r_cpu_ack <= w_ack_now && !r_src;
      r_kbd_ack <= w_ack_now && r_src;
      unique case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_src   <= w_gnt[1];
            r_char  <= w_gnt[1] ? kbd_char : cpu_char;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_print) begin
            if (w_full) begin
              r_state <= ST_SHIFT;
            end else begin
              for (int i = 0; i < SYMBOLS; i++)
                if (5'(i) == r_count) r_slots[i] <= r_char;
              r_count <= r_count + 5'd1;
              r_state <= ST_RELEASE;
            end
          end else if (w_bs) begin
            // i+1 == count never matches at count 0, so an empty line is untouched
            for (int i = 0; i < SYMBOLS; i++)
              if (5'(i) + 5'd1 == r_count) r_slots[i] <= '0;
            if (r_count != 5'd0) r_count <= r_count - 5'd1;
            r_state <= ST_RELEASE;
          end else if (w_clr_code) begin
            r_clr_idx <= '0;
            r_state   <= ST_CLEAR;
          end else begin
            r_state <= ST_RELEASE;
          end
        end
        ST_SHIFT: begin
          for (int i = 0; i < SYMBOLS - 1; i++) r_slots[i] <= r_slots[i+1];
          r_slots[SYMBOLS-1] <= r_char;
          r_state <= ST_RELEASE;
        end
        ST_CLEAR: begin
          for (int i = 0; i < SYMBOLS; i++)
            if (IW'(i) == r_clr_idx) r_slots[i] <= '0;
          if (w_clr_last) begin
            r_count <= '0;
            r_state <= ST_RELEASE;
          end else begin
            r_clr_idx <= r_clr_idx + IW'(1);
          end
        end
        ST_RELEASE: begin
          if (!w_src_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < SYMBOLS; g++) begin : g_out
    assign characters[g*CHAR_W +: CHAR_W] = r_slots[g];
  end

  assign count   = r_count;
  assign busy    = r_state != ST_IDLE;
  assign cpu_ack = r_cpu_ack;
  assign kbd_ack = r_kbd_ack;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: append, scroll, arbitration,
// backspace, clear, reset abort and held-request behaviour.
module tb_vga_text_ctrl;

  logic         clk_50 = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [6:0]   cpu_char;
  logic         cpu_ack;
  logic         kbd_req;
  logic [6:0]   kbd_char;
  logic         kbd_ack;
  logic [111:0] characters;
  logic [4:0]   count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  vga_text_ctrl dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_char   (cpu_char),
    .cpu_ack    (cpu_ack),
    .kbd_req    (kbd_req),
    .kbd_char   (kbd_char),
    .kbd_ack    (kbd_ack),
    .characters (characters),
    .count      (count),
    .busy       (busy)
  );

  always #10 clk_50 = ~clk_50;

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] slot(input int i);
    return characters[i*7 +: 7];
  endfunction

  // Raise a request, measure cycles to ack, then drop it and expect IDLE.
  task automatic send(input bit kbd, input logic [6:0] ch,
                      input int exp_lat, input string tag);
    int lat;
    lat = 0;
    if (kbd) begin kbd_char = ch; kbd_req = 1'b1; end
    else     begin cpu_char = ch; cpu_req = 1'b1; end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if ((kbd ? kbd_ack : cpu_ack) === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    if (kbd) kbd_req = 1'b0;
    else     cpu_req = 1'b0;
    tick();
    check({tag, "_ackpulse"}, kbd ? kbd_ack : cpu_ack, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int acks;
    reset    = 1'b1;
    cpu_req  = 1'b0;
    kbd_req  = 1'b0;
    cpu_char = '0;
    kbd_char = '0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 5'd0);
    check("rst_chars", characters, 112'd0);
    check("rst_acks", {cpu_ack, kbd_ack}, 2'b00);
    tick();
    reset = 1'b0;
    tick();

    cpu_char = 7'h41;
    cpu_req  = 1'b1;
    tick();
    check("first_ack_early", cpu_ack, 1'b0);
    check("first_busy", busy, 1'b1);
    tick();
    check("first_ack", cpu_ack, 1'b1);
    check("first_slot0", slot(0), 7'h41);
    check("first_count", count, 5'd1);
    cpu_req = 1'b0;
    tick();
    check("first_idle", busy, 1'b0);

    for (int c = 8'h42; c <= 8'h50; c++) send(1'b0, 7'(c), 2, "fill");
    check("fill_count", count, 5'd16);
    check("fill_slot15", slot(15), 7'h50);
    send(1'b0, 7'h51, 3, "scroll");
    check("scroll_slot0", slot(0), 7'h42);
    check("scroll_slot14", slot(14), 7'h50);
    check("scroll_slot15", slot(15), 7'h51);
    check("scroll_count", count, 5'd16);

    send(1'b0, 7'h0A, 18, "lf_full");
    check("lf_full_chars", characters, 112'd0);
    check("lf_full_count", count, 5'd0);

    cpu_char = 7'h31;
    kbd_char = 7'h32;
    cpu_req  = 1'b1;
    kbd_req  = 1'b1;
    tick();
    tick();
    check("pair1_cpu_ack", cpu_ack, 1'b1);
    check("pair1_kbd_ack", kbd_ack, 1'b0);
    cpu_req = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (kbd_ack === 1'b1) begin lat = n; break; end
    end
    check("pair1_kbd_lat", lat, 3);
    kbd_req = 1'b0;
    tick();
    check("pair1_slot0", slot(0), 7'h31);
    check("pair1_slot1", slot(1), 7'h32);

    cpu_char = 7'h33;
    kbd_char = 7'h34;
    cpu_req  = 1'b1;
    kbd_req  = 1'b1;
    tick();
    tick();
    check("pair2_kbd_ack", kbd_ack, 1'b1);
    check("pair2_cpu_ack", cpu_ack, 1'b0);
    kbd_req = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (cpu_ack === 1'b1) begin lat = n; break; end
    end
    check("pair2_cpu_lat", lat, 3);
    cpu_req = 1'b0;
    tick();
    check("pair2_slot2", slot(2), 7'h34);
    check("pair2_slot3", slot(3), 7'h33);
    check("pair2_count", count, 5'd4);

    send(1'b1, 7'h08, 2, "bs4");
    check("bs4_count", count, 5'd3);
    check("bs4_slot3", slot(3), 7'h00);
    send(1'b0, 7'h08, 2, "bs3");
    check("bs3_count", count, 5'd2);
    check("bs3_slot2", slot(2), 7'h00);
    send(1'b0, 7'h08, 2, "bs2");
    check("bs2_count", count, 5'd1);
    check("bs2_slot1", slot(1), 7'h00);
    send(1'b0, 7'h08, 2, "bs1");
    check("bs1_count", count, 5'd0);
    check("bs1_slot0", slot(0), 7'h00);
    send(1'b0, 7'h08, 2, "bs0");
    check("bs0_count", count, 5'd0);

    for (int c = 8'h61; c <= 8'h65; c++) send(1'b0, 7'(c), 2, "five");
    check("five_count", count, 5'd5);
    send(1'b0, 7'h0A, 18, "lf5");
    check("lf5_chars", characters, 112'd0);
    check("lf5_count", count, 5'd0);

    send(1'b1, 7'h07, 2, "discard");
    check("discard_count", count, 5'd0);

    for (int c = 8'h61; c <= 8'h63; c++) send(1'b0, 7'(c), 2, "three");
    cpu_char = 7'h0C;
    cpu_req  = 1'b1;
    repeat (10) tick();
    check("midclr_busy", busy, 1'b1);
    check("midclr_ack", cpu_ack, 1'b0);
    check("midclr_count", count, 5'd3);
    reset = 1'b1;
    #1;
    check("rstclr_busy", busy, 1'b0);
    check("rstclr_count", count, 5'd0);
    check("rstclr_chars", characters, 112'd0);
    check("rstclr_acks", {cpu_ack, kbd_ack}, 2'b00);
    cpu_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    cpu_char = 7'h41;
    cpu_req  = 1'b1;
    acks     = 0;
    repeat (50) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    check("hold_acks", acks, 1);
    check("hold_count", count, 5'd1);
    cpu_req = 1'b0;
    tick();
    check("hold_idle", busy, 1'b0);

    cpu_char = 7'h42;
    cpu_req  = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    send(1'b0, 7'h42, 2, "rst_hold");
    check("rst_hold_slot0", slot(0), 7'h42);
    check("rst_hold_count", count, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
